// File: rtl/di_term_pkg.sv
// Shared constants and helpers for terminals on the device-interface (di_*) bus.
//   Terminal addresses, transfer status codes, the bad-read marker and the
//   half-word select used by 32-bit terminals.
package di_term_pkg;

   // Terminal address map
   localparam logic [15:0] DI_TERM_NONE     = 16'h0000;
   localparam logic [15:0] DI_TERM_RAM_FAST = 16'h0005;
   localparam logic [15:0] DI_TERM_RAM_WIDE = 16'h0009;
   localparam logic [15:0] DI_TERM_RAM_SLOW = 16'h0002;

   // Transfer status codes
   localparam logic [15:0] DI_STATUS_OK    = 16'h0000;
   localparam logic [15:0] DI_STATUS_RANGE = 16'h0001;
   localparam logic [15:0] DI_STATUS_UNDEF = 16'hFFFF;

   // Returned on reads outside the terminal's address space
   localparam logic [15:0] DI_BAD_READ = 16'hDEAD;

   // Select the low or high 16-bit half of a (zero-extended) memory word
   function automatic logic [15:0] di_pick_half(input logic [31:0] word, input logic hi);
      return hi ? word[31:16] : word[15:0];
   endfunction

endpackage

// File: rtl/di_ram_terminal_if.sv
// Device-interface (di_*) bus between host interface and one terminal.
//   master: host side, drives address/mode/strobes/write data.
//   slave : terminal side, drives read data, ready flags and status.
// Terminal outputs are zero when the terminal is not addressed, so several
// slaves can be merged with a bitwise OR.
interface di_ram_terminal_if;

   logic [15:0] di_term_addr;
   logic [31:0] di_reg_addr;
   logic        di_read_mode;
   logic        di_write_mode;
   logic        di_read_req;
   logic        di_read;
   logic        di_write;
   logic [15:0] di_reg_datai;
   logic [15:0] di_reg_datao;
   logic        di_read_rdy;
   logic        di_write_rdy;
   logic [15:0] di_transfer_status;

   modport master (
      output di_term_addr, di_reg_addr, di_read_mode, di_write_mode,
             di_read_req, di_read, di_write, di_reg_datai,
      input  di_reg_datao, di_read_rdy, di_write_rdy, di_transfer_status
   );

   modport slave (
      input  di_term_addr, di_reg_addr, di_read_mode, di_write_mode,
             di_read_req, di_read, di_write, di_reg_datai,
      output di_reg_datao, di_read_rdy, di_write_rdy, di_transfer_status
   );

endinterface

// File: rtl/di_wait_counter.sv
// Wait-state counter for slow di_* terminals.
//   ifclk, resetb : clock, synchronous active-low reset
//   clr           : force counter to zero (terminal deselected)
//   load          : restart the wait with WAIT_STATES cycles
//   zero          : counter is zero (terminal may report ready)
// WAIT_STATES = 0 keeps the counter at zero permanently. Maximum is 255.
module di_wait_counter #(
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic ifclk,
   input  logic resetb,
   input  logic clr,
   input  logic load,
   output logic zero
);

   localparam int unsigned CNT_W = 8;

   logic [CNT_W-1:0] wcnt;

   // Load dominates decrement; clear dominates load
   always_ff @(posedge ifclk) begin
      if (!resetb || clr) begin
         wcnt <= '0;
      end else if (load) begin
         wcnt <= CNT_W'(WAIT_STATES);
      end else if (wcnt != '0) begin
         wcnt <= wcnt - CNT_W'(1);
      end
   end

   assign zero = (wcnt == '0);

endmodule

// File: rtl/di_ram_terminal.sv
// Parametrised RAM terminal on the di_* bus.
//   ifclk, resetb : clock, synchronous active-low reset
//   bus (slave)   : di_* transfer signals; all outputs are 0 when
//                   di_term_addr != TERM_ADDR so terminals can be OR-merged.
// DATA_WIDTH 16 or 32; in 32-bit mode di_reg_addr[0] picks the half and a
// low-half write is held until the matching high-half write commits the word.
// Accesses with address bits above the word index set a sticky range error
// which clears on an idle cycle (terminal selected, no transfer mode).
module di_ram_terminal
   import di_term_pkg::*;
#(
   parameter logic [15:0] TERM_ADDR   = DI_TERM_NONE,
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned ADDR_WIDTH  = 12,
   parameter int unsigned WAIT_STATES = 0
) (
   input logic         ifclk,
   input logic         resetb,
   di_ram_terminal_if.slave bus
);

   localparam bit          WIDE      = (DATA_WIDTH == 32);
   localparam bit          HAS_WAIT  = (WAIT_STATES != 0);
   localparam int unsigned HALF_BITS = WIDE ? 1 : 0;
   localparam int unsigned LO_BITS   = ADDR_WIDTH + HALF_BITS;
   localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;

   logic                  sel_c;
   logic                  oor_c;
   logic                  half_c;
   logic [ADDR_WIDTH-1:0] idx_c;
   logic                  wr_mem_c;
   logic                  wr_hold_c;
   logic                  rd_c;
   logic                  err_set_c;
   logic                  idle_c;
   logic                  clr_c;
   logic                  load_c;
   logic [DATA_WIDTH-1:0] wdata_c;
   logic                  wait_zero;
   logic                  unused_read;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [15:0]           rdata;
   logic [15:0]           hold;
   logic                  err;

   // Address decode
   assign sel_c  = (bus.di_term_addr == TERM_ADDR);
   assign oor_c  = ((bus.di_reg_addr >> LO_BITS) != 32'd0);
   assign idx_c  = ADDR_WIDTH'(bus.di_reg_addr >> HALF_BITS);
   assign half_c = WIDE && bus.di_reg_addr[0];

   // Transfer qualifiers
   assign wr_mem_c  = sel_c && bus.di_write && !oor_c && (!WIDE || half_c);
   assign wr_hold_c = sel_c && bus.di_write && !oor_c && WIDE && !half_c;
   assign rd_c      = sel_c && bus.di_read_req;
   assign err_set_c = sel_c && (bus.di_write || bus.di_read_req) && oor_c;
   assign idle_c    = sel_c && !bus.di_read_mode && !bus.di_write_mode;

   // High-half write commits the held low half alongside it
   assign wdata_c = WIDE ? DATA_WIDTH'({bus.di_reg_datai, hold})
                         : DATA_WIDTH'(bus.di_reg_datai);

   // di_read carries no state for a RAM terminal
   assign unused_read = bus.di_read;

   // Memory array, contents not reset
   always_ff @(posedge ifclk) begin
      if (wr_mem_c) begin
         mem[idx_c] <= wdata_c;
      end
   end

   // Read data, half-word hold and sticky error
   always_ff @(posedge ifclk) begin
      if (!resetb) begin
         rdata <= '0;
         hold  <= '0;
         err   <= 1'b0;
      end else begin
         if (rd_c) begin
            rdata <= oor_c ? DI_BAD_READ : di_pick_half(32'(mem[idx_c]), half_c);
         end
         if (wr_hold_c) begin
            hold <= bus.di_reg_datai;
         end else if (idle_c) begin
            hold <= '0;
         end
         if (err_set_c) begin
            err <= 1'b1;
         end else if (idle_c) begin
            err <= 1'b0;
         end
      end
   end

   // Wait states; deselect clears so a reselected terminal starts ready
   assign clr_c  = !sel_c;
   assign load_c = sel_c && (bus.di_read_req || bus.di_write);

   di_wait_counter #(
      .WAIT_STATES (WAIT_STATES)
   ) u_wait (
      .ifclk  (ifclk),
      .resetb (resetb),
      .clr    (clr_c),
      .load   (load_c),
      .zero   (wait_zero)
   );

   // OR-combinable outputs
   assign bus.di_reg_datao       = sel_c ? rdata : 16'h0000;
   assign bus.di_read_rdy        = sel_c && wait_zero && !(HAS_WAIT && bus.di_read_req);
   assign bus.di_write_rdy       = sel_c && wait_zero && !(HAS_WAIT && bus.di_write);
   assign bus.di_transfer_status = (sel_c && err) ? DI_STATUS_RANGE : DI_STATUS_OK;

endmodule

// File: tb/tb_di_ram_terminal.sv
// Bench for di_ram_terminal: three terminals (fast 16-bit, wide 32-bit with
// waits, slow 16-bit) share one host stimulus stream; a behavioural model
// predicts every output every cycle, plus directed checks on fixed values.
module tb_di_ram_terminal;
   import di_term_pkg::*;

   localparam int          NDUT  = 3;
   localparam logic [15:0] T_A   = 16'h0005;
   localparam logic [15:0] T_B   = 16'h0009;
   localparam logic [15:0] T_C   = 16'h0002;
   localparam logic [15:0] T_OFF = 16'h0077;

   int          cfg_dw   [NDUT] = '{16, 32, 16};
   int          cfg_aw   [NDUT] = '{12, 4, 6};
   int          cfg_ws   [NDUT] = '{0, 20, 63};
   logic [15:0] cfg_term [NDUT] = '{T_A, T_B, T_C};
   string       cfg_name [NDUT] = '{"A", "B", "C"};

   logic ifclk = 1'b0;
   logic resetb;
   always #5 ifclk = ~ifclk;

   // Host-side stimulus, broadcast to every terminal
   logic [15:0] h_term;
   logic [31:0] h_addr;
   logic        h_rmode, h_wmode, h_req, h_read, h_write;
   logic [15:0] h_datai;

   di_ram_terminal_if if_a ();
   di_ram_terminal_if if_b ();
   di_ram_terminal_if if_c ();

   always_comb begin
      if_a.di_term_addr = h_term;  if_b.di_term_addr = h_term;  if_c.di_term_addr = h_term;
      if_a.di_reg_addr  = h_addr;  if_b.di_reg_addr  = h_addr;  if_c.di_reg_addr  = h_addr;
      if_a.di_read_mode = h_rmode; if_b.di_read_mode = h_rmode; if_c.di_read_mode = h_rmode;
      if_a.di_write_mode = h_wmode; if_b.di_write_mode = h_wmode; if_c.di_write_mode = h_wmode;
      if_a.di_read_req  = h_req;   if_b.di_read_req  = h_req;   if_c.di_read_req  = h_req;
      if_a.di_read      = h_read;  if_b.di_read      = h_read;  if_c.di_read      = h_read;
      if_a.di_write     = h_write; if_b.di_write     = h_write; if_c.di_write     = h_write;
      if_a.di_reg_datai = h_datai; if_b.di_reg_datai = h_datai; if_c.di_reg_datai = h_datai;
   end

   logic [15:0] o_datao [NDUT];
   logic        o_rrdy  [NDUT];
   logic        o_wrdy  [NDUT];
   logic [15:0] o_stat  [NDUT];

   assign o_datao[0] = if_a.di_reg_datao; assign o_rrdy[0] = if_a.di_read_rdy;
   assign o_wrdy[0]  = if_a.di_write_rdy; assign o_stat[0] = if_a.di_transfer_status;
   assign o_datao[1] = if_b.di_reg_datao; assign o_rrdy[1] = if_b.di_read_rdy;
   assign o_wrdy[1]  = if_b.di_write_rdy; assign o_stat[1] = if_b.di_transfer_status;
   assign o_datao[2] = if_c.di_reg_datao; assign o_rrdy[2] = if_c.di_read_rdy;
   assign o_wrdy[2]  = if_c.di_write_rdy; assign o_stat[2] = if_c.di_transfer_status;

   di_ram_terminal #(.TERM_ADDR(T_A), .DATA_WIDTH(16), .ADDR_WIDTH(12), .WAIT_STATES(0))
      u_a (.ifclk(ifclk), .resetb(resetb), .bus(if_a));
   di_ram_terminal #(.TERM_ADDR(T_B), .DATA_WIDTH(32), .ADDR_WIDTH(4), .WAIT_STATES(20))
      u_b (.ifclk(ifclk), .resetb(resetb), .bus(if_b));
   di_ram_terminal #(.TERM_ADDR(T_C), .DATA_WIDTH(16), .ADDR_WIDTH(6), .WAIT_STATES(63))
      u_c (.ifclk(ifclk), .resetb(resetb), .bus(if_c));

   // Reference model state
   logic [31:0] m_mem    [int];
   logic [15:0] m_rdata  [NDUT];
   bit          m_rvalid [NDUT];
   logic [15:0] m_hold   [NDUT];
   bit          m_err    [NDUT];
   int          m_busy   [NDUT];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h want %h", tag, $time, obs, exp);
      end
   endtask

   function automatic int mkey(input int d, input int idx);
      return d * 65536 + idx;
   endfunction

   function automatic int lo_bits(input int d);
      return cfg_aw[d] + ((cfg_dw[d] == 32) ? 1 : 0);
   endfunction

   // Predicted outputs from model state and current inputs
   task automatic check_outputs();
      for (int d = 0; d < NDUT; d++) begin
         bit sel;
         bit exp_r, exp_w;
         sel   = (h_term == cfg_term[d]);
         exp_r = sel && (cfg_ws[d] == 0 || (m_busy[d] == 0 && !h_req));
         exp_w = sel && (cfg_ws[d] == 0 || (m_busy[d] == 0 && !h_write));
         chk({cfg_name[d], "_rrdy"}, 32'(o_rrdy[d]), 32'(exp_r));
         chk({cfg_name[d], "_wrdy"}, 32'(o_wrdy[d]), 32'(exp_w));
         chk({cfg_name[d], "_stat"}, 32'(o_stat[d]), (sel && m_err[d]) ? 32'd1 : 32'd0);
         if (!sel || m_rvalid[d])
            chk({cfg_name[d], "_datao"}, 32'(o_datao[d]), sel ? 32'(m_rdata[d]) : 32'd0);
      end
   endtask

   // Advance the model across one rising edge
   task automatic model_edge();
      for (int d = 0; d < NDUT; d++) begin
         bit          sel, oor, hi, wide, idle, hold_ld;
         int          idx;
         logic [31:0] w;
         logic [15:0] old_hold;
         if (!resetb) begin
            m_rdata[d] = 16'h0; m_rvalid[d] = 1'b1; m_hold[d] = 16'h0;
            m_err[d] = 1'b0;    m_busy[d] = 0;
            continue;
         end
         sel = (h_term == cfg_term[d]);
         if (!sel) begin
            m_busy[d] = 0;
            continue;
         end
         wide     = (cfg_dw[d] == 32);
         oor      = ((h_addr >> lo_bits(d)) != 32'd0);
         hi       = wide && h_addr[0];
         idx      = int'((h_addr >> (wide ? 1 : 0)) & ((32'd1 << cfg_aw[d]) - 32'd1));
         old_hold = m_hold[d];
         idle     = !h_rmode && !h_wmode;
         hold_ld  = h_write && !oor && wide && !hi;
         if (h_req) begin
            if (oor) begin
               m_rdata[d] = DI_BAD_READ; m_rvalid[d] = 1'b1;
            end else if (m_mem.exists(mkey(d, idx))) begin
               w = m_mem[mkey(d, idx)];
               m_rdata[d] = hi ? w[31:16] : w[15:0]; m_rvalid[d] = 1'b1;
            end else begin
               m_rvalid[d] = 1'b0;
            end
         end
         if (h_write && !oor) begin
            if (!wide)      m_mem[mkey(d, idx)] = {16'h0, h_datai};
            else if (hi)    m_mem[mkey(d, idx)] = {h_datai, old_hold};
         end
         if (hold_ld)   m_hold[d] = h_datai;
         else if (idle) m_hold[d] = 16'h0;
         if ((h_write || h_req) && oor) m_err[d] = 1'b1;
         else if (idle)                 m_err[d] = 1'b0;
         if (cfg_ws[d] > 0 && (h_req || h_write)) m_busy[d] = cfg_ws[d];
         else if (m_busy[d] > 0)                  m_busy[d] = m_busy[d] - 1;
      end
   endtask

   // One clock: check just after the falling edge, step the model at the rise
   task automatic step();
      #1 check_outputs();
      @(posedge ifclk);
      model_edge();
      @(negedge ifclk);
   endtask

   task automatic wr_txn(input logic [15:0] term, input logic [31:0] addr, input logic [15:0] data,
                         input int n, input int hold_cyc, input bit idle);
      h_term = term; h_wmode = 1'b1; h_rmode = 1'b0; h_req = 1'b0;
      for (int i = 0; i < n; i++) begin
         h_addr = addr + 32'(i); h_datai = data + 16'(i); h_write = 1'b1;
         step();
      end
      h_write = 1'b0;
      repeat (hold_cyc) step();
      if (idle) begin h_wmode = 1'b0; step(); end
   endtask

   task automatic rd_pulse(input logic [15:0] term, input logic [31:0] addr);
      h_term = term; h_rmode = 1'b1; h_wmode = 1'b0; h_addr = addr; h_req = 1'b1;
      step();
      h_req = 1'b0;
   endtask

   task automatic rd_txn(input logic [15:0] term, input logic [31:0] addr,
                         input int hold_cyc, input bit idle);
      rd_pulse(term, addr);
      repeat (hold_cyc) step();
      h_read = 1'b1; step(); h_read = 1'b0;
      if (idle) begin h_rmode = 1'b0; step(); end
   endtask

   initial begin
      int low;
      h_term = 16'h0; h_addr = 32'h0; h_rmode = 1'b0; h_wmode = 1'b0;
      h_req = 1'b0; h_read = 1'b0; h_write = 1'b0; h_datai = 16'h0;
      resetb = 1'b0;
      step(); step();
      resetb = 1'b1;

      // Reset state seen by a selected terminal
      h_term = T_A;
      #1 chk("A_rst_rrdy", 32'(o_rrdy[0]), 32'd1);
      chk("A_rst_stat", 32'(o_stat[0]), 32'd0);
      chk("A_rst_datao", 32'(o_datao[0]), 32'd0);
      step();

      // Fast 16-bit write / read back with one-cycle latency
      wr_txn(T_A, 32'd7, 16'h1234, 1, 0, 1'b1);
      h_term = T_A; h_rmode = 1'b1; h_addr = 32'd7; h_req = 1'b1;
      #1 chk("A_rrdy_during_req", 32'(o_rrdy[0]), 32'd1);
      step();
      h_req = 1'b0;
      #1 chk("A_rd_1234", 32'(o_datao[0]), 32'h1234);
      chk("A_stat_ok", 32'(o_stat[0]), 32'd0);
      h_rmode = 1'b0; step();

      // 32-bit packing
      h_term = T_B; h_wmode = 1'b1; h_addr = 32'd0; h_datai = 16'hBEEF; h_write = 1'b1; step();
      h_addr = 32'd1; h_datai = 16'hCAFE; step();
      h_write = 1'b0; h_wmode = 1'b0; step();
      rd_pulse(T_B, 32'd1); #1 chk("B_rd_hi_CAFE", 32'(o_datao[1]), 32'hCAFE);
      rd_pulse(T_B, 32'd0); #1 chk("B_rd_lo_BEEF", 32'(o_datao[1]), 32'hBEEF);
      h_rmode = 1'b0; step();
      wr_txn(T_B, 32'd3, 16'h1111, 1, 0, 1'b1);
      rd_pulse(T_B, 32'd2); #1 chk("B_hi_alone_lo0", 32'(o_datao[1]), 32'h0000);
      rd_pulse(T_B, 32'd3); #1 chk("B_hi_alone_hi", 32'(o_datao[1]), 32'h1111);
      h_rmode = 1'b0; step();

      // Out of range on the 12-bit terminal
      wr_txn(T_A, 32'd0, 16'h0A0A, 1, 0, 1'b1);
      h_term = T_A; h_wmode = 1'b1; h_addr = 32'd4096; h_datai = 16'h5555; h_write = 1'b1; step();
      h_write = 1'b0;
      #1 chk("A_rng_stat_wr", 32'(o_stat[0]), 32'd1);
      rd_pulse(T_A, 32'd4096);
      #1 chk("A_rng_DEAD", 32'(o_datao[0]), 32'hDEAD);
      chk("A_rng_stat_rd", 32'(o_stat[0]), 32'd1);
      h_rmode = 1'b0; step();
      #1 chk("A_rng_stat_idle", 32'(o_stat[0]), 32'd0);
      rd_pulse(T_A, 32'd0);
      #1 chk("A_rng_mem_kept", 32'(o_datao[0]), 32'h0A0A);
      h_rmode = 1'b0; step();

      // Slow terminal: ready low for the write cycle plus 63 waits
      for (int k = 0; k < 4; k++) begin
         h_term = T_C; h_wmode = 1'b1; h_rmode = 1'b0; h_addr = 32'(k);
         h_datai = 16'hC000 + 16'(k); h_write = 1'b1; low = 0;
         for (int i = 0; i < 200; i++) begin
            #1; if (o_wrdy[2]) break;
            low++; step(); h_write = 1'b0;
         end
         chk("C_wr_low_cycles", 32'(low), 32'd64);
      end
      for (int k = 0; k < 4; k++) begin
         h_term = T_C; h_rmode = 1'b1; h_wmode = 1'b0; h_addr = 32'(k);
         h_req = 1'b1; low = 0;
         for (int i = 0; i < 200; i++) begin
            #1; if (o_rrdy[2]) break;
            low++; step(); h_req = 1'b0;
         end
         chk("C_rd_low_cycles", 32'(low), 32'd64);
         chk("C_rd_data", 32'(o_datao[2]), 32'hC000 + 32'(k));
      end
      h_rmode = 1'b0; step();

      // Deselect mid-wait, foreign write pulses, then reselect
      wr_txn(T_C, 32'd10, 16'h2222, 1, 3, 1'b0);
      h_term = T_OFF; h_addr = 32'd1; h_datai = 16'hFFFF;
      repeat (3) begin h_write = 1'b1; step(); h_write = 1'b0; step(); end
      h_term = T_C; h_wmode = 1'b0;
      #1 chk("C_reselect_wrdy", 32'(o_wrdy[2]), 32'd1);
      chk("C_reselect_rrdy", 32'(o_rrdy[2]), 32'd1);
      step();
      rd_pulse(T_C, 32'd1); #1 chk("C_mem_untouched", 32'(o_datao[2]), 32'hC001);
      h_rmode = 1'b0; step();

      // Reset during a wait
      h_term = T_B; h_wmode = 1'b1; h_addr = 32'd5; h_datai = 16'h7777; h_write = 1'b1; step();
      h_write = 1'b0;
      repeat (4) step();
      resetb = 1'b0; step(); resetb = 1'b1;
      #1 chk("B_rst_wait_wrdy", 32'(o_wrdy[1]), 32'd1);
      chk("B_rst_wait_rrdy", 32'(o_rrdy[1]), 32'd1);
      chk("B_rst_wait_stat", 32'(o_stat[1]), 32'd0);
      chk("B_rst_wait_datao", 32'(o_datao[1]), 32'd0);
      h_wmode = 1'b0; step();

      // Randomised transfers across all terminals and a foreign address
      for (int t = 0; t < 250; t++) begin
         int          d, cd, lo, hc;
         logic [15:0] term;
         logic [31:0] addr;
         d    = $urandom_range(0, 3);
         cd   = (d == 3) ? $urandom_range(0, 2) : d;
         term = (d == 3) ? T_OFF : cfg_term[cd];
         lo   = lo_bits(cd);
         addr = $urandom & ((32'd1 << lo) - 32'd1);
         if ($urandom_range(0, 7) == 0) addr = addr | (32'd1 << $urandom_range(lo, 31));
         hc = $urandom_range(0, cfg_ws[cd] + 2);
         if ($urandom_range(0, 1) == 1)
            wr_txn(term, addr, 16'($urandom), $urandom_range(1, 2), hc, $urandom_range(0, 3) != 0);
         else
            rd_txn(term, addr, hc, $urandom_range(0, 3) != 0);
         if ($urandom_range(0, 39) == 0) begin
            resetb = 1'b0; step(); resetb = 1'b1;
         end
      end
      h_rmode = 1'b0; h_wmode = 1'b0; step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/di_ram_terminal.md
Name: di_ram_terminal

Overview:
- Parametrised RAM terminal on the device-interface (di_*) bus behind the host interface.
- Replaces the separate fast/slow RAM terminals with one block.
- Configurable terminal address, memory width (16 or 32 bit), depth and wait-state count.
- Adds out-of-range error status and OR-combinable outputs, so top-level terminal muxes reduce to a bitwise OR.

Parameters:
- TERM_ADDR, 16'h0000: terminal address this block responds to.
- DATA_WIDTH, 16: memory word width; legal values 16 or 32.
- ADDR_WIDTH, 12: log2 of memory depth in DATA_WIDTH words.
- WAIT_STATES, 0: ready-deassert cycles after each read request or write. 0 means always ready. Maximum 255.

Ports:
- ifclk, in, 1: clock.
- resetb, in, 1: synchronous active-low reset.
- di_term_addr, in, 16: terminal address of the current transfer.
- di_reg_addr, in, 32: register address in 16-bit units.
- di_read_mode, in, 1: read transfer in progress.
- di_write_mode, in, 1: write transfer in progress.
- di_read_req, in, 1: read request strobe, one cycle before di_read.
- di_read, in, 1: host consumed di_reg_datao.
- di_write, in, 1: di_reg_datai valid this cycle.
- di_reg_datai, in, 16: write data.
- di_reg_datao, out, 16: read data; 0 when not selected.
- di_read_rdy, out, 1: read data ready; 0 when not selected.
- di_write_rdy, out, 1: able to accept a write; 0 when not selected.
- di_transfer_status, out, 16: status; 0 when not selected.

Behaviour:
- Clock is ifclk. Reset is resetb: synchronous, active-low.
- sel = (di_term_addr == TERM_ADDR). All outputs are forced to 0 when !sel.
- Half-word mapping:
  - DATA_WIDTH=16: word index = di_reg_addr[ADDR_WIDTH-1:0].
  - DATA_WIDTH=32: word index = di_reg_addr[ADDR_WIDTH:1]; half = di_reg_addr[0] (0=low, 1=high).
- Out of range: any di_reg_addr bit above the index/half bits is set.
- Write (sel && di_write && in range):
  - DATA_WIDTH=16: mem[idx] <= di_reg_datai.
  - DATA_WIDTH=32, low half: hold <= di_reg_datai; no memory write.
  - DATA_WIDTH=32, high half: mem[idx] <= {di_reg_datai, hold}.
- Read (sel && di_read_req && in range): rdata <= selected half of mem[idx] on the next edge. di_reg_datao = rdata. Latency is 1 cycle from di_read_req.
- Out-of-range access:
  - Write is dropped. A read loads rdata <= 16'hDEAD.
  - Sticky err <= 1.
- Error status:
  - di_transfer_status = {15'b0, err}.
  - err and hold clear to 0 on any cycle with sel && !di_read_mode && !di_write_mode (idle between transfers).
  - If a clear and a new error coincide, the error wins.
- Wait states:
  - WAIT_STATES=0: di_read_rdy = di_write_rdy = sel.
  - WAIT_STATES>0, 8-bit counter wcnt: on sel && (di_read_req || di_write), wcnt <= WAIT_STATES.
  - Otherwise wcnt decrements while nonzero.
  - di_read_rdy = sel && wcnt==0 && !di_read_req.
  - di_write_rdy = sel && wcnt==0 && !di_write.
  - When !sel, wcnt <= 0, so a newly selected terminal starts ready.
- Reset:
  - rdata=0, hold=0, err=0, wcnt=0. Memory contents are not reset.
  - Reset during a wait clears wcnt; ready asserts on the first cycle after reset if sel.
- The host does not assert di_read_req and di_write in the same cycle. If it does, the write is performed, the read is performed, and wcnt reloads once.

Decomposition:
- Package di_term_pkg:
  - Terminal address constants.
  - DI_STATUS_OK=16'h0000, DI_STATUS_RANGE=16'h0001, DI_STATUS_UNDEF=16'hFFFF.
  - DI_BAD_READ=16'hDEAD.
- Sub-module di_wait_counter: params WAIT_STATES; inputs ifclk, resetb, clr, load; output zero. Reused by future slow peripheral terminals.
- Memory inferred inline as a synchronous-read array.

Test Plan:
- Fast 16-bit (WAIT_STATES=0, TERM_ADDR=5): write 0x1234 to addr 7, read back → di_reg_datao=0x1234 one cycle after di_read_req; rdy held 1; status=0.
- Slow (WAIT_STATES=63): write 4 words → di_write_rdy low for exactly 64 cycles after each di_write. Read back → di_read_rdy low 64 cycles after di_read_req, then data correct.
- 32-bit pack (DATA_WIDTH=32, ADDR_WIDTH=4):
  - Write addr 0=0xBEEF then addr 1=0xCAFE → mem[0]=0xCAFEBEEF.
  - Read addr 1 → 0xCAFE.
  - Write high half alone after idle → low half=0x0000.
- Range (ADDR_WIDTH=12): write addr 4096 → no memory change, status=0x0001. Read → 0xDEAD. Status stays 1 until both modes go low, then 0.
- Deselect: di_term_addr≠TERM_ADDR with di_write pulses → memory unchanged; all outputs 0; wcnt cleared; reselect → rdy=1 immediately.
- Reset mid-wait (WAIT_STATES=20): resetb low at wait cycle 5 → after release wcnt=0, rdy=1, status=0, di_reg_datao=0.
